// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
// Purpose: loader FSM state encoding and word geometry.
// Ports: none (package).
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CKSUM,
        DONE
    } t_ldr_state;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_word_packer.sv
// rtl/prog_loader_word_packer.sv - little-endian byte-to-word packer
// Purpose: collects WORD_BYTES stream bytes into one 32-bit word.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          restart packing at byte 0
//   byte_en        a byte transfers this cycle
//   byte_data      the transferring byte
//   word           packed word; complete while word_full is high
//   word_full      high on the transfer that supplies the last byte
module prog_loader_word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt_q;
    // Holds the first three bytes; the fourth comes straight from the input
    // so the full word is available on the same cycle as its last byte.
    logic [23:0]      sr_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (byte_en) begin
            cnt_q <= cnt_q + 1'b1;
            sr_q  <= {byte_data, sr_q[23:8]};
        end
    end

    assign word      = {byte_data, sr_q};
    assign word_full = byte_en && (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - instruction memory writer fed by a byte stream
// Purpose: packs streamed bytes into 32-bit words, writes them to consecutive
// word addresses from BASE_ADDR, and holds the core in reset until done.
// Optional macro PROG_LOADER_CHECKSUM_EN: trailing 32-bit checksum word,
// compared against the running sum of written words; mismatch sets err_o.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i, num_words_i          begin a load of num_words_i words (IDLE only)
//   byte_data_i/valid_i/ready_o   byte stream handshake
//   mem_addr_o/wr_en_o/data_o     memory write port
//   core_hold_o                   keep the core in reset
//   busy_o, done_o, err_o         status
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_words_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_en_o,
    output logic [31:0]       mem_data_o,
    output logic              core_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    t_ldr_state        state_q, state_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;
    logic              hold_q;

    logic              start_ok;
    logic              xfer;
    logic              last_word;
    logic              pk_full;
    logic [31:0]       pk_word;
    logic [ADDR_W-1:0] cur_addr;

    assign start_ok  = (state_q == IDLE) && start_i;
    assign xfer      = byte_valid_i && byte_ready_o;
    assign last_word = (word_idx_q + (ADDR_W+1)'(1)) == count_q;
    // Truncation to ADDR_W bits gives the silent wrap past the top word.
    assign cur_addr  = ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];

    prog_loader_word_packer u_packer (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (start_ok),
        .byte_en   (xfer),
        .byte_data (byte_data_i),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_words_i == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready_o = 1'b1;
                if (pk_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CKSUM: begin
                byte_ready_o = 1'b1;
                if (pk_full) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            word_idx_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hold_q     <= 1'b1;
        end else begin
            if (start_ok) begin
                count_q    <= (num_words_i > MAX_COUNT) ? MAX_COUNT : num_words_i;
                word_idx_q <= '0;
                hold_q     <= 1'b1;
            end
            // Address and data are captured on the last byte so they are
            // stable through WRITE and keep their value afterwards.
            if ((state_q == COLLECT) && pk_full) begin
                mem_addr_q <= cur_addr;
                mem_data_q <= pk_word;
            end
            if (state_q == WRITE) begin
                word_idx_q <= word_idx_q + (ADDR_W+1)'(1);
            end
            if (state_q == DONE) begin
                hold_q <= 1'b0;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                sum_q <= '0;
                err_q <= 1'b0;
            end else if ((state_q == COLLECT) && pk_full) begin
                sum_q <= sum_q + pk_word;
            end
            if ((state_q == CKSUM) && pk_full && (pk_word != sum_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign mem_wr_en_o = (state_q == WRITE);
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    // Hold drops in the DONE cycle itself, together with the done pulse.
    assign core_hold_o = hold_q && (state_q != DONE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [31:0]       mem_data;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       exp_words[4];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .num_words_i  (num_words),
        .byte_data_i  (byte_data),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .mem_addr_o   (mem_addr),
        .mem_wr_en_o  (mem_wr_en),
        .mem_data_o   (mem_data),
        .core_hold_o  (core_hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            check("ready_in_write", 32'(byte_ready), 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte_wait_timeout", 32'(t >= 50), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic start_load(input int n);
        start     = 1'b1;
        num_words = n[ADDR_W:0];
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 32'(t >= 200), 32'd0);
        check("hold_at_done", 32'(core_hold), 32'd0);
    endtask

    task automatic run_load(input int n, input bit gap);
        logic [31:0] sum;
        sum = '0;
        wr_addr_q.delete();
        wr_data_q.delete();
        start_load(n);
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_after_start", 32'(core_hold), 32'd1);
        for (int i = 0; i < n; i++) begin
            send_word(exp_words[i], gap);
            sum = sum + exp_words[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(sum, gap);
`endif
        wait_done();
        check("write_count", 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("write_addr", 32'(wr_addr_q[i]), 32'(i));
            check("write_data", wr_data_q[i], exp_words[i]);
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("hold_after_done", 32'(core_hold), 32'd0);
    endtask

    initial begin
        exp_words[0] = 32'h0000_0013;
        exp_words[1] = 32'h0010_0093;
        exp_words[2] = 32'hDEAD_BEEF;
        exp_words[3] = 32'h0A0B_0C0D;
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_data  = 8'h00;
        byte_valid = 1'b1;

        // Reset state, with a byte offered throughout
        repeat (2) @(negedge clk);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", mem_data, 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_hold", 32'(core_hold), 32'd1);
        byte_valid = 1'b0;

        // Basic two-word load
        run_load(2, 1'b0);

        // Same stream with gaps between bytes
        run_load(2, 1'b1);

        // Zero-word load: done on the next cycle, no writes
        wr_addr_q.delete();
        start_load(0);
        check("zero_done", 32'(done), 32'd1);
        @(negedge clk);
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_writes", 32'(wr_addr_q.size()), 32'd0);

        // Reset after two bytes abandons the load
        wr_addr_q.delete();
        start_load(2);
        send_byte(8'h13);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(core_hold), 32'd1);
        @(negedge clk);
        check("midrst_writes", 32'(wr_addr_q.size()), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        run_load(3, 1'b0);

        // start while busy is ignored
        wr_addr_q.delete();
        wr_data_q.delete();
        start_load(1);
        send_byte(8'h44);
        send_byte(8'h33);
        start     = 1'b1;
        num_words = '0;
        @(negedge clk);
        start     = 1'b0;
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_done", 32'(done), 32'd0);
        send_byte(8'h22);
        send_byte(8'h11);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(32'h1122_3344, 1'b0);
`endif
        wait_done();
        check("busy_start_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() > 0) check("busy_start_data", wr_data_q[0], 32'h1122_3344);
        if (wr_addr_q.size() > 0) check("busy_start_addr", 32'(wr_addr_q[0]), 32'd0);
        @(negedge clk);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Correct checksum 0x001000A6
        start_load(2);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_word(32'h0010_00A6, 1'b0);
        wait_done();
        check("ck_good_err", 32'(err), 32'd0);
        @(negedge clk);
        // Wrong checksum 0x001000A7
        start_load(2);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_word(32'h0010_00A7, 1'b0);
        wait_done();
        check("ck_bad_err_done", 32'(err), 32'd1);
        @(negedge clk);
        check("ck_bad_err_sticky", 32'(err), 32'd1);
        start_load(2);
        check("ck_err_cleared", 32'(err), 32'd0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_word(32'h0010_00A6, 1'b0);
        wait_done();
        check("ck_final_err", 32'(err), 32'd0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory. The decoder and control path read program words from memory; this block fills memory with those words.
- Accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them to consecutive word addresses.
- Holds the core in reset until a load completes. Sits beside the memory and drives its write port, muxed in top while core_hold_o is high.

Parameters:
- ADDR_W, 10, word-address width; must match the memory word-address width.
- BASE_ADDR, 0, word address of the first word written.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  begin a load; sampled only in IDLE
- num_words_i  in  ADDR_W+1  number of words to load; sampled with start_i
- byte_data_i  in  8  stream byte
- byte_valid_i  in  1  byte_data_i is valid
- byte_ready_o  out  1  loader accepts a byte this cycle
- mem_addr_o  out  ADDR_W  word address to memory
- mem_wr_en_o  out  1  one-cycle write strobe
- mem_data_o  out  32  packed word
- core_hold_o  out  1  keep the core in reset
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse when a load finishes
- err_o  out  1  checksum mismatch, sticky (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 except core_hold_o=1. FSM goes to IDLE; byte counter, word index and shift register clear.
- A byte transfers only on a cycle where byte_valid_i && byte_ready_o.
- FSM states: IDLE, COLLECT, WRITE, [CKSUM], DONE.
- IDLE:
  - start_i=1 and num_words_i>0: latch the count (saturated to 2**ADDR_W), clear word index, set core_hold_o=1, go to COLLECT.
  - start_i=1 and num_words_i=0: go to DONE with no writes.
- COLLECT:
  - byte_ready_o=1.
  - Byte k (0..3) of a word lands in bits [8k+7:8k].
  - On the 4th transfer, go to WRITE.
- WRITE (exactly one cycle):
  - mem_wr_en_o=1, mem_addr_o = (BASE_ADDR + word_idx) mod 2**ADDR_W, mem_data_o = packed word.
  - byte_ready_o=0.
  - Increment word_idx. If word_idx+1 equals the count, go to DONE (or CKSUM if enabled); otherwise go to COLLECT.
- DONE: done_o=1 for one cycle, core_hold_o cleared, return to IDLE.
- mem_wr_en_o is 0 in every state except WRITE. mem_addr_o and mem_data_o hold their last values otherwise.
- Throughput: at best 5 cycles per word (4 byte cycles + 1 write cycle). Gaps in byte_valid_i stall without losing data.
- start_i while busy_o=1 is ignored.
- Address wrap past 2**ADDR_W-1 wraps to 0 silently.
- rst_i during a load abandons it: the partial word is discarded, no write is issued, and the block returns to reset values.
- busy_o=1 in every state except IDLE.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN
- With the macro defined:
  - A running 32-bit sum (mod 2**32) of all written words is kept.
  - After the last WRITE, the FSM enters CKSUM and collects 4 more bytes (little-endian) with byte_ready_o=1.
  - A mismatch with the sum sets err_o. err_o stays set until the next accepted start_i or reset.
  - DONE is still reached and core_hold_o still clears.
- Without the macro: no CKSUM state, no sum register, err_o tied to 0.

Decomposition:
- Shared package (the existing riscv package): typedef t_ldr_state enum {IDLE, COLLECT, WRITE, CKSUM, DONE}, and constant WORD_BYTES=4.
- Sub-module word_packer: byte shift register plus 2-bit byte counter. Outputs the packed word and a word_full pulse; cleared by the FSM.

Test Plan:
- Reset: after rst_i=1 for 2 cycles, core_hold_o=1, all other outputs 0, and byte_ready_o stays 0 while byte_valid_i=1.
- Basic load, BASE_ADDR=0, num_words_i=2:
  - Stimulus: bytes 13 00 00 00 93 00 10 00.
  - Required: write addr 0 data 0x00000013, then addr 1 data 0x00100093; done_o pulses; core_hold_o falls the same cycle.
- Backpressure: same stream with byte_valid_i toggling every other cycle. Required: identical writes, and byte_ready_o=0 in each WRITE cycle.
- Zero words: start_i with num_words_i=0 gives done_o on the next cycle and no mem_wr_en_o.
- Reset mid-load: assert rst_i after 2 bytes. Required: no write, FSM in IDLE, core_hold_o=1. A following full load then writes correctly from BASE_ADDR.
- Checksum (macro defined), 2-word load as above:
  - Checksum bytes A6 00 10 00 (0x001000A6): err_o=0.
  - Checksum bytes A7 00 10 00: err_o=1, still set after done_o, cleared by the next start_i.
